// File: rtl/run_det_pkg.sv
// Shared definitions for the run-detector scheduler.
// Holds the FSM state encoding, channel/counter widths and the round-robin
// winner selection helper used by the top-level arbiter.
package run_det_pkg;

  localparam int unsigned NUM_CH     = 4;
  localparam int unsigned ID_W       = 2;
  localparam int unsigned RC_W       = 3;
  localparam int unsigned RC_MAX     = 7;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned THRESH_MIN = 2;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_GRANT = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // First requesting id found scanning upward from ptr, wrapping modulo NUM_CH.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                               input logic [ID_W-1:0]   ptr);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;
    logic            found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr + ID_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/run_det_core.sv
// Run-length detector datapath shared by all requesters.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clr_i          - clear run counter, previous bit, z and detection count
//   en_i           - sample bit_i this cycle
//   bit_i          - serial data bit of the granted requester
//   thresh_i       - effective run-length threshold (already clamped to >= 2)
//   z_o            - registered detection flag for the most recent sample
//   det_cnt_o      - saturating count of detections in the current burst
module run_det_core
  import run_det_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic [RC_W-1:0]  thresh_i,
  output logic             z_o,
  output logic [CNT_W-1:0] det_cnt_o
);

  logic [RC_W-1:0]  rc_q, rc_d, rc_new;
  logic             prev_q, prev_d;
  logic             z_q, z_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  always_comb begin
    // rc_q == 0 marks the first bit of a burst; either polarity forms a run
    if (rc_q == '0 || bit_i != prev_q) begin
      rc_new = RC_W'(1);
    end else if (rc_q == RC_W'(RC_MAX)) begin
      rc_new = rc_q;
    end else begin
      rc_new = rc_q + RC_W'(1);
    end
    hit = (rc_new >= thresh_i);

    rc_d   = rc_q;
    prev_d = prev_q;
    z_d    = z_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      rc_d   = '0;
      prev_d = 1'b0;
      z_d    = 1'b0;
      cnt_d  = '0;
    end else if (en_i) begin
      rc_d   = rc_new;
      prev_d = bit_i;
      z_d    = hit;
      if (hit && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rc_q   <= '0;
      prev_q <= 1'b0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rc_q   <= rc_d;
      prev_q <= prev_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
    end
  end

  assign z_o       = z_q;
  assign det_cnt_o = cnt_q;

endmodule

// File: rtl/run_det_sched.sv
// Round-robin scheduler granting one of four requesters access to a shared
// run-length detector for one serial burst.
// Ports:
//   clock, rst      - clock, asynchronous active-low reset
//   req, w, last    - per-requester request, serial bit, final-bit marker
//   thresh          - run-length threshold, sampled while granting (0/1 -> 2)
//   gnt, busy       - one-hot grant, non-idle indicator
//   z               - registered detection flag for the latest sample
//   done, done_id   - one-cycle end-of-burst pulse and finished id
//   abort           - burst ended by request withdrawal (valid with done)
//   det_cnt         - detections in the burst (valid with done)
module run_det_sched
  import run_det_pkg::*;
(
  input  logic         clock,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [3:0]   w,
  input  logic [3:0]   last,
  input  logic [2:0]   thresh,
  output logic [3:0]   gnt,
  output logic         busy,
  output logic         z,
  output logic         done,
  output logic [1:0]   done_id,
  output logic         abort,
  output logic [7:0]   det_cnt
);

  state_t          state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [RC_W-1:0] th_q, th_d;
  logic            abort_q, abort_d;
  logic            core_clr, core_en;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    th_d     = th_q;
    abort_d  = abort_q;
    core_clr = 1'b0;
    core_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          id_d    = rr_pick(req, ptr_q);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        core_clr = 1'b1;
        abort_d  = 1'b0;
        th_d     = (thresh < RC_W'(THRESH_MIN)) ? RC_W'(THRESH_MIN) : thresh;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        // last wins over a simultaneous withdrawal: the bit is still processed
        if (last[id_q]) begin
          core_en = 1'b1;
          state_d = ST_DONE;
        end else if (!req[id_q]) begin
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          core_en = 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = id_q + ID_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      th_q    <= RC_W'(THRESH_MIN);
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      th_q    <= th_d;
      abort_q <= abort_d;
    end
  end

  run_det_core u_core (
    .clk_i     (clock),
    .rst_ni    (rst),
    .clr_i     (core_clr),
    .en_i      (core_en),
    .bit_i     (w[id_q]),
    .thresh_i  (th_q),
    .z_o       (z),
    .det_cnt_o (det_cnt)
  );

  assign gnt     = (state_q == ST_GRANT || state_q == ST_RUN) ? (NUM_CH'(1) << id_q) : '0;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign done_id = done ? id_q : '0;
  assign abort   = done & abort_q;

endmodule

// File: tb/tb_run_det_sched.sv
// Directed bench for run_det_sched: table of bursts with hand-computed
// per-sample z and end-of-burst results, plus sequences for saturation and
// mid-burst reset.
module tb_run_det_sched;

  logic       clock;
  logic       rst;
  logic [3:0] req;
  logic [3:0] w;
  logic [3:0] last;
  logic [2:0] thresh;
  logic [3:0] gnt;
  logic       busy;
  logic       z;
  logic       done;
  logic [1:0] done_id;
  logic       abort;
  logic [7:0] det_cnt;

  int total = 0;
  int bad   = 0;

  run_det_sched dut (
    .clock   (clock),
    .rst     (rst),
    .req     (req),
    .w       (w),
    .last    (last),
    .thresh  (thresh),
    .gnt     (gnt),
    .busy    (busy),
    .z       (z),
    .done    (done),
    .done_id (done_id),
    .abort   (abort),
    .det_cnt (det_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  req_v;
    logic [2:0]  th;
    logic [15:0] bits;      // bit i = i-th sample
    int          len;
    bit          wd;        // withdraw req after len bits
    bit          drop_last; // drop req in the same cycle as last
    bit          keep;      // leave req asserted after the burst
    logic [1:0]  id;
    logic [7:0]  det;
    bit          ab;
    logic [15:0] zm;        // expected z after each sample
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic burst(input vec_t v);
    logic [3:0] oh;
    bit         is_last;
    int         n;
    oh     = 4'b0001 << v.id;
    req    = v.req_v;
    thresh = v.th;
    n = 0;
    while (gnt == 4'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("gnt_grant", 32'(gnt), 32'(oh));
    @(negedge clock);
    // threshold must already be latched
    thresh = ~v.th;
    chk("z_clr", 32'(z), 32'd0);
    chk("cnt_clr", 32'(det_cnt), 32'd0);
    for (int i = 0; i < v.len; i++) begin
      is_last = (i == v.len - 1) && !v.wd;
      w       = v.bits[i] ? oh : ~oh;
      last    = is_last ? oh : ~oh;
      if (is_last && v.drop_last) req = req & ~oh;
      @(negedge clock);
      chk($sformatf("z_bit%0d", i), 32'(z), 32'(v.zm[i]));
      if (!is_last) chk("gnt_run", 32'(gnt), 32'(oh));
    end
    if (v.wd) begin
      req  = req & ~oh;
      w    = oh;
      last = ~oh;
      @(negedge clock);
    end
    chk("done", 32'(done), 32'd1);
    chk("done_id", 32'(done_id), 32'(v.id));
    chk("det_cnt", 32'(det_cnt), 32'(v.det));
    chk("abort", 32'(abort), 32'(v.ab));
    chk("gnt_done", 32'(gnt), 32'd0);
    chk("busy_done", 32'(busy), 32'd1);
    if (!v.keep) req = 4'b0;
    w    = 4'b0;
    last = 4'b0;
    @(negedge clock);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{4'b0001, 3'd4, 16'h001F, 5, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2, 1'b0, 16'h0018};
    vecs[1]  = '{4'b0001, 3'd0, 16'h000C, 4, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2, 1'b0, 16'h000A};
    vecs[2]  = '{4'b0100, 3'd2, 16'h0007, 3, 1'b1, 1'b0, 1'b0, 2'd2, 8'd2, 1'b1, 16'h0006};
    vecs[3]  = '{4'b1000, 3'd2, 16'h0001, 1, 1'b0, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0, 16'h0000};
    vecs[4]  = '{4'b0010, 3'd3, 16'h0078, 7, 1'b0, 1'b0, 1'b0, 2'd1, 8'd3, 1'b0, 16'h0064};
    vecs[5]  = '{4'b0011, 3'd1, 16'h0001, 3, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 1'b0, 16'h0004};
    vecs[6]  = '{4'b0100, 3'd7, 16'h00FF, 8, 1'b0, 1'b0, 1'b0, 2'd2, 8'd2, 1'b0, 16'h00C0};
    vecs[7]  = '{4'b1000, 3'd2, 16'h0003, 2, 1'b0, 1'b1, 1'b0, 2'd3, 8'd1, 1'b0, 16'h0002};
    vecs[8]  = '{4'b1111, 3'd2, 16'h0003, 2, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1, 1'b0, 16'h0002};
    vecs[9]  = '{4'b1111, 3'd2, 16'h0003, 2, 1'b0, 1'b0, 1'b1, 2'd1, 8'd1, 1'b0, 16'h0002};
    vecs[10] = '{4'b1111, 3'd2, 16'h0003, 2, 1'b0, 1'b0, 1'b1, 2'd2, 8'd1, 1'b0, 16'h0002};
    vecs[11] = '{4'b1111, 3'd2, 16'h0003, 2, 1'b0, 1'b0, 1'b1, 2'd3, 8'd1, 1'b0, 16'h0002};
    vecs[12] = '{4'b1111, 3'd2, 16'h0003, 2, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1, 1'b0, 16'h0002};

    rst    = 1'b0;
    req    = 4'b0;
    w      = 4'b0;
    last   = 4'b0;
    thresh = 3'd2;
    @(negedge clock);
    chk("reset_outs", 32'({gnt, busy, z, done, done_id, abort, det_cnt}), 32'd0);
    rst = 1'b1;
    @(negedge clock);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 13; i++) burst(vecs[i]);

    // Saturation: 300 consecutive ones, threshold 3
    req    = 4'b0001;
    thresh = 3'd3;
    n = 0;
    while (gnt == 4'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("sat_gnt", 32'(gnt), 32'h1);
    @(negedge clock);
    for (int i = 0; i < 300; i++) begin
      w    = 4'b0001;
      last = (i == 299) ? 4'b0001 : 4'b0000;
      @(negedge clock);
    end
    chk("sat_done", 32'(done), 32'd1);
    chk("sat_cnt", 32'(det_cnt), 32'd255);
    chk("sat_z", 32'(z), 32'd1);
    req  = 4'b0;
    w    = 4'b0;
    last = 4'b0;
    @(negedge clock);

    // Asynchronous reset in the middle of a burst
    req    = 4'b0100;
    thresh = 3'd2;
    n = 0;
    while (gnt == 4'b0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      w = 4'b0100;
      @(negedge clock);
    end
    chk("mid_z", 32'(z), 32'd1);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 chk("mid_reset_outs", 32'({gnt, busy, z, done, done_id, abort, det_cnt}), 32'd0);
    req = 4'b0;
    w   = 4'b0;
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("post_reset_idle", 32'(busy), 32'd0);
    req = 4'b1110;
    @(negedge clock);
    chk("post_reset_gnt", 32'(gnt), 32'b0010);
    req = 4'b0;
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
